zacore_mem_responder: RTL and testbench

- Memory-side responder for the Zacore core memory interface.
- Services instruction fetches and data reads/writes from one single-port, byte-enabled, word-addressed backing array.
- Adds configurable wait states and round-robin arbitration between the fetch and data ports.
- Returns results with per-port acknowledge pulses; used as the simulation/FPGA memory beside the core.

---
 rtl/zacore_mem_pkg.sv | 10 +
 rtl/zacore_mem_sram.sv | 34 +++
 rtl/zacore_mem_responder.sv | 137 +++++++++++++
 tb/tb_zacore_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/zacore_mem_pkg.sv
// Shared types and widths for the Zacore memory responder.
package zacore_mem_pkg;

   localparam int XLEN   = 32;
   localparam int MASK_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESPOND} mem_state_t;
   typedef enum logic {PORT_FETCH, PORT_DATA} mem_port_t;

endpackage

// File: rtl/zacore_mem_sram.sv
// Single-port synchronous word array with byte enables; a write edge also
// returns the word as it was before the write.
module zacore_mem_sram
   import zacore_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter string       INIT_FILE   = ""
) (
   input  logic                           i_clk,
   input  logic                           i_en,
   input  logic                           i_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
   input  logic [XLEN-1:0]                i_wdata,
   input  logic [MASK_W-1:0]              i_mask,
   output logic [XLEN-1:0]                o_rdata
);

   logic [XLEN-1:0] mem_q [DEPTH_WORDS];
   logic [XLEN-1:0] rdata_q;

   always_ff @(posedge i_clk) begin
      if (i_en) begin
         rdata_q <= mem_q[i_idx];
         if (i_we) begin
            for (int b = 0; b < MASK_W; b++) begin
               if (i_mask[b]) mem_q[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/zacore_mem_responder.sv
// Memory-side responder: round-robin fetch/data arbiter, wait-state FSM,
// address decode and held response registers around one single-port array.
module zacore_mem_responder
   import zacore_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_fetch_req,
   input  logic [31:0]       i_fetch_addr,
   output logic [XLEN-1:0]   o_inst_read,
   output logic              o_fetch_ack,
   input  logic              i_read_req,
   input  logic              i_write_req,
   input  logic [31:0]       i_data_addr,
   input  logic [XLEN-1:0]   i_data_write,
   input  logic [MASK_W-1:0] i_data_write_mask,
   output logic [XLEN-1:0]   o_data_read,
   output logic              o_data_ack,
   output logic              o_fault
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [29:0] BASE_W   = BASE_ADDR[31:2];
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   mem_state_t        state_q;
   mem_port_t         port_q, last_grant_q, grant_d;
   logic [3:0]        cnt_q;
   logic [29:0]       addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [MASK_W-1:0] mask_q;
   logic              wr_q;
   logic              fetch_ack_q, data_ack_q, fault_q;
   logic [XLEN-1:0]   inst_q, data_q;

   logic              fetch_pend, data_pend, in_range, sram_en;
   logic [29:0]       woff;
   logic [XLEN-1:0]   sram_rdata, rsp_word;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{i_fetch_addr[1:0], i_data_addr[1:0]};

   assign fetch_pend = i_fetch_req;
   assign data_pend  = i_read_req | i_write_req;

   always_comb begin
      grant_d = PORT_FETCH;
      if (fetch_pend && data_pend)
         grant_d = (last_grant_q == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
      else if (data_pend)
         grant_d = PORT_DATA;
   end

   // Word-granular decode; the compare is widened so DEPTH_WORDS up to 2^30 fits.
   assign woff     = addr_q - BASE_W;
   assign in_range = (addr_q >= BASE_W) && ({2'b00, woff} < 32'(DEPTH_WORDS));
   assign sram_en  = (state_q == ACCESS) && in_range;

   zacore_mem_sram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .INIT_FILE  (INIT_FILE)
   ) u_sram (
      .i_clk  (i_clk),
      .i_en   (sram_en),
      .i_we   (sram_en && wr_q),
      .i_idx  (woff[AW-1:0]),
      .i_wdata(wdata_q),
      .i_mask (mask_q),
      .o_rdata(sram_rdata)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         port_q       <= PORT_FETCH;
         last_grant_q <= PORT_FETCH;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
         wr_q         <= 1'b0;
         fetch_ack_q  <= 1'b0;
         data_ack_q   <= 1'b0;
         fault_q      <= 1'b0;
         inst_q       <= '0;
         data_q       <= '0;
      end else begin
         fetch_ack_q <= 1'b0;
         data_ack_q  <= 1'b0;
         fault_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fetch_pend || data_pend) begin
                  port_q       <= grant_d;
                  last_grant_q <= grant_d;
                  addr_q       <= (grant_d == PORT_FETCH) ? i_fetch_addr[31:2] : i_data_addr[31:2];
                  wdata_q      <= i_data_write;
                  mask_q       <= i_data_write_mask;
                  wr_q         <= (grant_d == PORT_DATA) && i_write_req;
                  cnt_q        <= WAIT_INIT;
                  state_q      <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) state_q <= ACCESS;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            ACCESS: begin
               fetch_ack_q <= (port_q == PORT_FETCH);
               data_ack_q  <= (port_q == PORT_DATA);
               fault_q     <= ~in_range;
               state_q     <= RESPOND;
            end
            RESPOND: begin
               if (fetch_ack_q) inst_q <= rsp_word;
               if (data_ack_q)  data_q <= rsp_word;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The array word is visible in the ack cycle and captured for holding after it.
   assign rsp_word    = fault_q ? '0 : sram_rdata;
   assign o_inst_read = fetch_ack_q ? rsp_word : inst_q;
   assign o_data_read = data_ack_q  ? rsp_word : data_q;
   assign o_fetch_ack = fetch_ack_q;
   assign o_data_ack  = data_ack_q;
   assign o_fault     = fault_q;

endmodule

// File: tb/tb_zacore_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops on each ack.
module tb_zacore_mem_responder;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_fetch_req = 1'b0;
   logic [31:0] i_fetch_addr = '0;
   logic [31:0] o_inst_read;
   logic        o_fetch_ack;
   logic        i_read_req = 1'b0;
   logic        i_write_req = 1'b0;
   logic [31:0] i_data_addr = '0;
   logic [31:0] i_data_write = '0;
   logic [3:0]  i_data_write_mask = '0;
   logic [31:0] o_data_read;
   logic        o_data_ack;
   logic        o_fault;

   always #5 i_clk = ~i_clk;

   zacore_mem_responder #(
      .DEPTH_WORDS(4096),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_CYCLES(1),
      .INIT_FILE  ("")
   ) dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_fetch_req      (i_fetch_req),
      .i_fetch_addr     (i_fetch_addr),
      .o_inst_read      (o_inst_read),
      .o_fetch_ack      (o_fetch_ack),
      .i_read_req       (i_read_req),
      .i_write_req      (i_write_req),
      .i_data_addr      (i_data_addr),
      .i_data_write     (i_data_write),
      .i_data_write_mask(i_data_write_mask),
      .o_data_read      (o_data_read),
      .o_data_ack       (o_data_ack),
      .o_fault          (o_fault)
   );

   typedef struct {
      logic [31:0] data;
      bit          chk;
      bit          fault;
   } exp_t;

   exp_t fq[$];
   exp_t dq[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every ack consumes one expected entry from its port's queue.
   always @(negedge i_clk) begin
      exp_t e;
      if (o_fetch_ack) begin
         if (fq.size() == 0) cmp("unexpected fetch ack", {31'b0, o_fetch_ack}, 32'd0);
         else begin
            e = fq.pop_front();
            if (e.chk) cmp("fetch data", o_inst_read, e.data);
            cmp("fetch fault", {31'b0, o_fault}, {31'b0, e.fault});
         end
      end
      if (o_data_ack) begin
         if (dq.size() == 0) cmp("unexpected data ack", {31'b0, o_data_ack}, 32'd0);
         else begin
            e = dq.pop_front();
            if (e.chk) cmp("data read", o_data_read, e.data);
            cmp("data fault", {31'b0, o_fault}, {31'b0, e.fault});
         end
      end
   end

   task automatic drop_reqs();
      i_fetch_req = 1'b0;
      i_read_req  = 1'b0;
      i_write_req = 1'b0;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      drop_reqs();
      repeat (2) @(negedge i_clk);
      cmp("reset acks/fault", {29'b0, o_fetch_ack, o_data_ack, o_fault}, 32'd0);
      cmp("reset inst_read", o_inst_read, 32'd0);
      cmp("reset data_read", o_data_read, 32'd0);
      i_rst = 1'b0;
   endtask

   // One transaction from IDLE; expected ack 3 cycles after the request cycle (WAIT_CYCLES=1).
   task automatic txn(input bit f, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdat, input logic [3:0] mask,
                      input logic [31:0] exp, input bit chk, input bit flt, input string name);
      exp_t e;
      int   lat;
      e.data = exp; e.chk = chk; e.fault = flt;
      @(posedge i_clk); #1;
      if (f) begin
         fq.push_back(e);
         i_fetch_req  = 1'b1;
         i_fetch_addr = addr;
      end else begin
         dq.push_back(e);
         i_read_req        = rd;
         i_write_req       = wr;
         i_data_addr       = addr;
         i_data_write      = wdat;
         i_data_write_mask = mask;
      end
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge i_clk);
         if (f ? o_fetch_ack : o_data_ack) begin
            lat = k;
            break;
         end
      end
      cmp({name, " latency"}, 32'(lat), 32'd3);
      if (lat < 0) begin
         if (f) e = fq.pop_back();
         else   e = dq.pop_back();
      end
      @(posedge i_clk); #1;
      drop_reqs();
      @(negedge i_clk);
      if (chk) cmp({name, " held"}, f ? o_inst_read : o_data_read, exp);
      cmp({name, " single pulse"}, {30'b0, o_fetch_ack, o_data_ack}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [1:0] exp_ack;

      do_reset();

      // basic write/fetch and byte-masked merges
      txn(0, 0, 1, 32'h0000_0000, 32'h0000_0013, 4'hF, 32'h0, 0, 0, "wr 0x0");
      txn(1, 0, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_0013, 1, 0, "fetch 0x0");
      txn(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, "wr 0x10 full");
      txn(0, 0, 1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0, 0, 0, "wr 0x10 byte0");
      txn(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 1, 0, "rd 0x10");
      txn(0, 1, 0, 32'h0000_0013, 32'h0, 4'h0, 32'hDEAD_BEAA, 1, 0, "rd misaligned 0x13");
      txn(1, 0, 0, 32'h0000_0012, 32'h0, 4'h0, 32'hDEAD_BEAA, 1, 0, "fetch misaligned 0x12");

      // read-before-write and empty mask
      txn(0, 0, 1, 32'h0000_0020, 32'h1111_1111, 4'hF, 32'h0, 0, 0, "wr 0x20");
      txn(0, 1, 1, 32'h0000_0020, 32'h2222_2222, 4'hC, 32'h1111_1111, 1, 0, "rd+wr 0x20");
      txn(0, 1, 0, 32'h0000_0020, 32'h0, 4'h0, 32'h2222_1111, 1, 0, "rd 0x20 after rmw");
      txn(0, 0, 1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, 0, "wr 0x20 mask0");
      txn(0, 1, 0, 32'h0000_0020, 32'h0, 4'h0, 32'h2222_1111, 1, 0, "rd 0x20 after mask0");

      // range boundary and out-of-range (0x4000 would alias word 0 if decode wrapped)
      txn(0, 0, 1, 32'h0000_3FFC, 32'h5A5A_5A5A, 4'hF, 32'h0, 0, 0, "wr last word");
      txn(0, 1, 0, 32'h0000_3FFC, 32'h0, 4'h0, 32'h5A5A_5A5A, 1, 0, "rd last word");
      txn(0, 1, 0, 32'h0000_4000, 32'h0, 4'h0, 32'h0, 1, 1, "rd oor");
      txn(0, 0, 1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 1, "wr oor");
      txn(1, 0, 0, 32'h0000_4000, 32'h0, 4'h0, 32'h0, 1, 1, "fetch oor");
      txn(0, 1, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_0013, 1, 0, "rd 0x0 after oor wr");
      txn(0, 1, 0, 32'h0000_3FFC, 32'h0, 4'h0, 32'h5A5A_5A5A, 1, 0, "rd last after oor wr");
      txn(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 1, 0, "rd 0x10 after oor wr");

      // arbitration: both ports held from cycle 0 right after reset
      do_reset();
      @(posedge i_clk); #1;
      e.chk = 1; e.fault = 0;
      for (int i = 0; i < 3; i++) begin
         e.data = 32'hDEAD_BEAA; dq.push_back(e);
         e.data = 32'h0000_0013; fq.push_back(e);
      end
      i_fetch_req  = 1'b1; i_fetch_addr = 32'h0000_0000;
      i_read_req   = 1'b1; i_data_addr  = 32'h0000_0010;
      for (int c = 0; c < 24; c++) begin
         @(negedge i_clk);
         exp_ack = (c % 8 == 3) ? 2'b01 : (c % 8 == 7) ? 2'b10 : 2'b00;
         cmp($sformatf("arb cycle %0d {fetch,data} ack", c), {30'b0, o_fetch_ack, o_data_ack}, {30'b0, exp_ack});
      end
      @(posedge i_clk); #1;
      drop_reqs();
      repeat (2) @(negedge i_clk);

      // reset during WAIT abandons the write
      txn(0, 0, 1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 0, "wr 0x30");
      @(posedge i_clk); #1;
      i_write_req = 1'b1; i_data_addr = 32'h0000_0030;
      i_data_write = 32'h1234_5678; i_data_write_mask = 4'hF;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1; #1;
      cmp("rst in wait acks/fault", {29'b0, o_fetch_ack, o_data_ack, o_fault}, 32'd0);
      cmp("rst in wait inst_read", o_inst_read, 32'd0);
      cmp("rst in wait data_read", o_data_read, 32'd0);
      drop_reqs();
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         cmp("no ack after abandoned write", {29'b0, o_fetch_ack, o_data_ack, o_fault}, 32'd0);
      end
      txn(0, 1, 0, 32'h0000_0030, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 0, "rd 0x30 after abandon");

      // reset during RESPOND drops the ack at once
      @(posedge i_clk); #1;
      e.data = 32'hDEAD_BEAA; e.chk = 1; e.fault = 0; dq.push_back(e);
      i_read_req = 1'b1; i_data_addr = 32'h0000_0010;
      repeat (4) @(negedge i_clk);
      cmp("ack before respond reset", {31'b0, o_data_ack}, 32'd1);
      #1 i_rst = 1'b1;
      #1;
      cmp("respond reset acks/fault", {29'b0, o_fetch_ack, o_data_ack, o_fault}, 32'd0);
      cmp("respond reset data_read", o_data_read, 32'd0);
      drop_reqs();
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      cmp("no ack after respond reset", {31'b0, o_data_ack}, 32'd0);

      repeat (2) @(negedge i_clk);
      cmp("fetch queue drained", 32'(fq.size()), 32'd0);
      cmp("data queue drained", 32'(dq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
